// File: rtl/matrix_product_scheduler.sv
// rtl/matrix_product_scheduler.sv - sequences one column processor over every cell of C = A*B
module matrix_product_scheduler #(
  parameter int size       = 4,
  parameter int cell_width = 8,
  parameter int width      = cell_width * size,
  parameter int timeout    = 64
) (
  input  logic                             in_clk,
  input  logic                             in_reset,
  input  logic                             in_ready,
  input  logic [size*size*cell_width-1:0]  in_mat_a,
  input  logic [size*size*cell_width-1:0]  in_mat_b,
  input  logic                             out_ack,
  output logic [size*size*cell_width-1:0]  out_mat_c,
  output logic                             out_ready,
  output logic                             out_error,
  output logic                             out_busy,
  output logic                             pe_ready,
  output logic [width-1:0]                 pe_row_a,
  output logic [width-1:0]                 pe_col_b,
  output logic                             pe_ack,
  input  logic                             pe_done,
  input  logic [width-1:0]                 pe_cell_c
);

  localparam int mat_w = size * size * cell_width;
  localparam int idx_w = (size > 1) ? $clog2(size) : 1;
  localparam int cnt_w = $clog2(timeout + 1);
  localparam logic [idx_w-1:0] last_idx = idx_w'(size - 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    DONE
  } state_t;

  state_t            state;
  logic [mat_w-1:0]  mat_a;
  logic [mat_w-1:0]  mat_b;
  logic [idx_w-1:0]  row_idx;
  logic [idx_w-1:0]  col_idx;
  logic [cnt_w-1:0]  wait_cnt;
  logic [width-1:0]  row_sel;
  logic [width-1:0]  col_sel;

  // select row i of A and column j of B; constant slices only, gated by index match
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    for (int r = 0; r < size; r++) begin
      for (int k = 0; k < size; k++) begin
        if (row_idx == idx_w'(r))
          row_sel[k*cell_width +: cell_width] = mat_a[(r*size + k)*cell_width +: cell_width];
        if (col_idx == idx_w'(r))
          col_sel[k*cell_width +: cell_width] = mat_b[(k*size + r)*cell_width +: cell_width];
      end
    end
  end

  // job sequencing FSM; every output is registered here
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state     <= IDLE;
      mat_a     <= '0;
      mat_b     <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      wait_cnt  <= '0;
      out_mat_c <= '0;
      out_ready <= 1'b0;
      out_error <= 1'b0;
      out_busy  <= 1'b0;
      pe_ready  <= 1'b0;
      pe_row_a  <= '0;
      pe_col_b  <= '0;
      pe_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready) begin
            mat_a     <= in_mat_a;
            mat_b     <= in_mat_b;
            out_mat_c <= '0;
            out_error <= 1'b0;
            row_idx   <= '0;
            col_idx   <= '0;
            out_busy  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          pe_row_a <= row_sel;
          pe_col_b <= col_sel;
          pe_ready <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          pe_ready <= 1'b0;
          wait_cnt <= wait_cnt + cnt_w'(1);
          if (pe_done) begin
            // result lands in the cell addressed by the current indices; upper bits are dropped
            for (int r = 0; r < size; r++) begin
              for (int c = 0; c < size; c++) begin
                if (row_idx == idx_w'(r) && col_idx == idx_w'(c))
                  out_mat_c[(r*size + c)*cell_width +: cell_width] <= pe_cell_c[cell_width-1:0];
              end
            end
            pe_ack <= 1'b1;
            state  <= RELEASE;
          end else if (wait_cnt == cnt_last) begin
            out_error <= 1'b1;
            out_ready <= 1'b1;
            state     <= DONE;
          end
        end
        RELEASE: begin
          if (!pe_done) begin
            pe_ack <= 1'b0;
            if (col_idx == last_idx) begin
              col_idx <= '0;
              row_idx <= row_idx + idx_w'(1);
            end else begin
              col_idx <= col_idx + idx_w'(1);
            end
            if (row_idx == last_idx && col_idx == last_idx) begin
              out_ready <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ack) begin
            out_ready <= 1'b0;
            out_busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_product_scheduler.md
Name: matrix_product_scheduler

Overview:
- Sequences one shared column-processor unit over every (i,j) cell of a size×size matrix product C = A·B.
- Accepts both operand matrices in one handshake and issues row i of A plus column j of B to the processor for each cell.
- Collects each scalar result and presents the complete C matrix with a ready/ack handshake.
- Sits between the coprocessor top-level job interface and the column-processor datapath.

Parameters:
- size, 4: matrix dimension (rows = cols = size), ≥1.
- cell_width, 8: bits per matrix element.
- width, cell_width*size: bits per row/column vector.
- timeout, 64: max cycles spent waiting for one processor result before the job aborts.

Ports:
- in_clk  input  1  clock, all state updates on rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_ready  input  1  job request; operands valid while high.
- in_mat_a  input  size*size*cell_width  A, row-major; A(i,k) at bits [(i*size+k)*cell_width +: cell_width].
- in_mat_b  input  size*size*cell_width  B, same layout.
- out_ack  input  1  consumer has taken the result.
- out_mat_c  output  size*size*cell_width  C, same layout.
- out_ready  output  1  C valid.
- out_error  output  1  job aborted on timeout.
- out_busy  output  1  high in every state except IDLE.
- pe_ready  output  1  start pulse to processor.
- pe_row_a  output  width  row i of A; element k at [k*cell_width +: cell_width].
- pe_col_b  output  width  column j of B; element k = B(k,j).
- pe_ack  output  1  acknowledge to processor.
- pe_done  input  1  processor result valid.
- pe_cell_c  input  width  processor result; only bits [cell_width-1:0] are used.

Behaviour:
- Reset (in_reset low, asynchronous): state IDLE. All outputs, out_mat_c, the internal A/B copies, the i/j indices and the timeout counter clear to 0.
- IDLE: if in_ready is high at the clock edge:
  - latch A and B;
  - clear out_mat_c and out_error;
  - set i=j=0;
  - go to ISSUE.
- ISSUE:
  - pe_row_a and pe_col_b take row i / column j.
  - pe_ready=1 for exactly this one cycle.
  - Timeout counter clears.
  - Go to WAIT.
- WAIT:
  - pe_ready=0; pe_row_a and pe_col_b hold their values.
  - Counter increments each cycle.
  - If pe_done: C(i,j) <= pe_cell_c[cell_width-1:0], pe_ack<=1, go to RELEASE.
  - Else if counter reaches timeout-1: out_error<=1, go to DONE.
  - pe_done takes priority over timeout in the same cycle.
- RELEASE:
  - pe_ack stays 1 until pe_done is sampled low.
  - Then pe_ack<=0 and the indices advance with j fastest: j+1; on j==size-1, j<=0 and i+1.
  - If (i,j) was (size-1,size-1), go to DONE; else go to ISSUE.
- DONE:
  - out_ready=1; out_mat_c and out_error are held stable.
  - On out_ack: go to IDLE, and out_ready is 0 from the next cycle.
- in_ready while not in IDLE is ignored; there is no queueing.
- Exactly size*size pe_ready pulses per successful job.
- Cells not yet written at abort read as 0.
- size=1: a single ISSUE/WAIT/RELEASE pass, then DONE.
- No arithmetic in this block; overflow/truncation belongs to the processor. The block only copies the low cell_width bits.
- Index counters are max($clog2(size),1) bits wide.
- Reset mid-job: abort immediately. No result and no pe_ack are produced; the processor is reset by its own reset path.

Test Plan:
- Bench setup for all scenarios: size=2, cell_width=8, behavioural processor model (dot product mod 256, latency L cycles, done held until ack).
- Basic product, L=3: A=[[1,2],[3,4]], B=[[5,6],[7,8]] → out_ready=1, C=[[19,22],[43,50]], out_error=0, exactly 4 pe_ready pulses in order (0,0),(0,1),(1,0),(1,1).
- Operand routing: same job → first issue shows pe_row_a={2,1}, pe_col_b={7,5} (element1,element0); the second issue shows pe_col_b={8,6}.
- Wrap/truncation: A=all 0x10, B=all 0x10 → every C cell = 0x00 (512 mod 256). Model with L=0 (done one cycle after start) → correct result, no lost cells.
- Timeout, timeout=64: model never asserts done → out_error=1 and out_ready=1 exactly 64 cycles after the first WAIT cycle; C=0. The next job clears out_error.
- Handshake, normal: out_ack withheld 10 cycles → out_ready and C stable throughout. A second in_ready pulse during the job is ignored, and only 4 pe_ready pulses occur.
- Reset mid-job: in_reset low during WAIT of cell (0,1) → all outputs 0 asynchronously; a subsequent job completes with correct C.
